reg_scoreboard: RTL
===================

// Module: reg_scoreboard
// PURPOSE
//   Producer-side register hazard tracker for the in-order issue stage. Counts outstanding
//   writes per architectural register: an issued instruction with a destination increments
//   the count, a writeback decrements it. Issue stalls while any source has a pending write
//   that the WB forwarding path cannot supply, or while the destination counter is saturated.
//   Complements the consumer-side forwarding mux select in EX.
// PARAMETERS
//   NUM_REGS  32  architectural registers tracked; x0 is never tracked
//   ADDR_W    5   register address width; NUM_REGS == 2**ADDR_W
//   CNT_W     2   per-register pending-write counter width; max in flight = 2**CNT_W-1
// PORTS
//   clk_i              in   1         clock, rising edge
//   rst_ni             in   1         asynchronous active-low reset
//   issue_valid_i      in   1         ID holds an instruction requesting issue
//   issue_use_rs1_i    in   1         instruction reads rs1
//   issue_use_rs2_i    in   1         instruction reads rs2
//   issue_rs1_i        in   ADDR_W    source 1 address
//   issue_rs2_i        in   ADDR_W    source 2 address
//   issue_reg_write_i  in   1         instruction writes rd
//   issue_rd_i         in   ADDR_W    destination address
//   issue_ready_o      out  1         1 = may issue this cycle; 0 = stall ID
//   wb_valid_i         in   1         a result is written to the register file this cycle
//   wb_rd_i            in   ADDR_W    writeback destination
//   busy_o             out  NUM_REGS  bit r = 1 when cnt[r] != 0 (registered state)
//   wb_err_o           out  1         sticky: writeback to a register whose cnt was 0
// BEHAVIOUR
//   - Reset (rst_ni=0, async): all cnt[r]=0, busy_o=0, wb_err_o=0; issue_ready_o then
//     equals 1 combinationally.
//   - fire = issue_valid_i & issue_ready_o. inc = fire & issue_reg_write_i & (issue_rd_i!=0).
//     dec = wb_valid_i & (wb_rd_i!=0) & (cnt[wb_rd_i]!=0).
//   - Per-register update on clk edge: inc&dec on same reg -> unchanged; inc only -> +1;
//     dec only -> -1. Never wraps: inc is blocked at max by stall; dec blocked at 0.
//   - wb_valid_i with wb_rd_i!=0 and cnt==0: no count change, wb_err_o set, held until reset.
//   - wb_rd_i==0 or issue_rd_i==0: ignored entirely (no count change, no error).
//   - Effective count eff[r] for the hazard check: see CONFIGURATION.
//   - RAW stall: issue_use_rs1_i & rs1!=0 & eff[rs1]!=0, same for rs2.
//   - Saturation stall: issue_reg_write_i & rd!=0 & cnt[rd]==2**CNT_W-1 (raw cnt, not eff).
//   - issue_ready_o = ~(RAW stall | saturation stall); purely combinational from inputs
//     and state, zero-cycle latency; independent of issue_valid_i.
//   - WAW below saturation is permitted; ordering of writebacks is the pipeline's duty.
//   - Instruction with rs == rd (e.g. addi x5,x5,1) checks sources against state before its
//     own inc.
//   - Reset mid-operation discards all pending counts; in-flight writebacks after reset
//     raise wb_err_o (benches must also reset the pipeline).
// CONFIGURATION
//   SCOREBOARD_WB_BYPASS_EN defined: eff[r] = cnt[r] - (dec hits r); an instruction
//     whose only pending producer writes back this cycle issues now, relying on the
//     WB->EX forwarding path.
//   Not defined: eff[r] = cnt[r]; consumer issues the cycle after writeback (one extra
//     stall cycle, no dependence on forwarding).
// STRUCTURE
//   - Shared package: ADDR_W, NUM_REGS, CNT_W defaults; typedef reg_addr_t; constant
//     REG_ZERO = '0.
//   - One sub-module natural: scoreboard_cnt (one saturating up/down counter, ports
//     inc/dec/cnt/at_max/nonzero), instantiated NUM_REGS-1 times via generate (r=1..31);
//     entry 0 tied to 0.
// TESTING
//   1 Reset: rst_ni=0 mid-run with cnt[3]=2 -> busy_o=0, wb_err_o=0, issue_ready_o=1
//     immediately.
//   2 Issue rd=5 cycle 0; next cycle rs1=5 -> ready=0; wb rd=5 cycle 3: with _EN ready=1
//     in cycle 3, without _EN ready=1 in cycle 4.
//   3 Issue rd=7 three times (CNT_W=2) -> busy_o[7]=1, 4th issue rd=7 ready=0; wb rd=7
//     -> ready=1 next cycle.
//   4 Same cycle: fire rd=9 and wb rd=9 with cnt[9]=1 -> cnt[9] stays 1, busy_o[9]=1.
//   5 rd=0 issue and rs1=0 with use_rs1=1 -> no busy bit, ready=1; wb rd=0 -> wb_err_o=0.
//   6 wb rd=12 with cnt[12]=0 -> wb_err_o=1 next cycle, held; cnt[12] stays 0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared sizes, address type and x0 constant for the register scoreboard
package reg_scoreboard_pkg;

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/writeback/status bundle between the pipeline and the scoreboard
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                issue_valid_i;
  logic                issue_use_rs1_i;
  logic                issue_use_rs2_i;
  reg_addr_t           issue_rs1_i;
  reg_addr_t           issue_rs2_i;
  logic                issue_reg_write_i;
  reg_addr_t           issue_rd_i;
  logic                issue_ready_o;
  logic                wb_valid_i;
  reg_addr_t           wb_rd_i;
  logic [NUM_REGS-1:0] busy_o;
  logic                wb_err_o;

  // Pipeline side: presents issue requests and writebacks, observes stall and status.
  modport master (
    output issue_valid_i, issue_use_rs1_i, issue_use_rs2_i, issue_rs1_i, issue_rs2_i,
    output issue_reg_write_i, issue_rd_i, wb_valid_i, wb_rd_i,
    input  issue_ready_o, busy_o, wb_err_o
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid_i, issue_use_rs1_i, issue_use_rs2_i, issue_rs1_i, issue_rs2_i,
    input  issue_reg_write_i, issue_rd_i, wb_valid_i, wb_rd_i,
    output issue_ready_o, busy_o, wb_err_o
  );

endinterface

// File: rtl/scoreboard_cnt.sv
// rtl/scoreboard_cnt.sv - one saturating up/down pending-write counter
module scoreboard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max,
  output logic             nonzero
);

  assign at_max  = &cnt;
  assign nonzero = |cnt;

  // Simultaneous inc and dec cancel; the end stops keep the count from wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && nonzero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write tracker and issue stall (SCOREBOARD_WB_BYPASS_EN lets same-cycle writeback clear a hazard)
module reg_scoreboard #(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_scoreboard_pkg::ADDR_W,
  parameter int CNT_W    = reg_scoreboard_pkg::CNT_W
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  reg_scoreboard_if.slave sb
);
  import reg_scoreboard_pkg::*;

  logic [ADDR_W-1:0] rs1, rs2, rd, wb_rd;
  logic [NUM_REGS-1:1][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0] at_max, nonzero, eff_busy;
  logic raw1, raw2, sat, ready, fire, wb_err;

  assign rs1   = sb.issue_rs1_i;
  assign rs2   = sb.issue_rs2_i;
  assign rd    = sb.issue_rd_i;
  assign wb_rd = sb.wb_rd_i;

  // x0 is never a hazard and never counts.
  assign at_max[0]   = 1'b0;
  assign nonzero[0]  = 1'b0;
  assign eff_busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic             inc, dec;
    logic [CNT_W-1:0] eff;

    assign inc = fire & sb.issue_reg_write_i & (rd == ADDR_W'(r));
    assign dec = sb.wb_valid_i & (wb_rd == ADDR_W'(r)) & nonzero[r];

`ifdef SCOREBOARD_WB_BYPASS_EN
    // A producer retiring this cycle is covered by the WB->EX forward path.
    assign eff = cnt[r] - CNT_W'(dec);
`else
    assign eff = cnt[r];
`endif
    assign eff_busy[r] = (eff != '0);

    scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc     (inc),
      .dec     (dec),
      .cnt     (cnt[r]),
      .at_max  (at_max[r]),
      .nonzero (nonzero[r])
    );
  end

  // Sources check state before this instruction's own increment, so rs == rd is safe.
  assign raw1  = sb.issue_use_rs1_i & (rs1 != REG_ZERO) & eff_busy[rs1];
  assign raw2  = sb.issue_use_rs2_i & (rs2 != REG_ZERO) & eff_busy[rs2];
  // Saturation looks at the raw count: a same-cycle writeback does not free a slot yet.
  assign sat   = sb.issue_reg_write_i & (rd != REG_ZERO) & at_max[rd];
  assign ready = ~(raw1 | raw2 | sat);
  assign fire  = sb.issue_valid_i & ready;

  // Sticky flag for a writeback that had no matching issued producer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_err <= 1'b0;
    end else if (sb.wb_valid_i && (wb_rd != REG_ZERO) && !nonzero[wb_rd]) begin
      wb_err <= 1'b1;
    end
  end

  assign sb.issue_ready_o = ready;
  assign sb.busy_o        = nonzero;
  assign sb.wb_err_o      = wb_err;

endmodule
